// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALUOp codes,
// state codes, datapath mux selects and the bundled control word.
package mips_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 4;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI  = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_LUI   = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALU_BEQ   = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALU_BNE   = 4'b1001;
    localparam logic [ALUOP_W-1:0] ALU_LW    = 4'b1010;
    localparam logic [ALUOP_W-1:0] ALU_SW    = 4'b1011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_R_EXEC   = 4'd3,
        S_I_EXEC   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic               pc_write;
        logic               ir_write;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               jal;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. MEM_READY_EN adds the mem_ready wait input.
interface multicycle_control_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]    op;
    logic               zero;
`ifdef MEM_READY_EN
    logic               mem_ready;
`endif
    logic               pc_write;
    logic               ir_write;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               jal;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
    logic [3:0]         state;

`ifdef MEM_READY_EN
    modport master (
        input  op, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, jal, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op, state
    );
    modport slave (
        output op, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, jal, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op, state
    );
`else
    modport master (
        input  op, zero,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, jal, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op, state
    );
    modport slave (
        output op, zero,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, jal, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op, state
    );
`endif

endinterface

// File: rtl/multicycle_output_decode.sv
// Combinational Moore output map: (state, op, zero, mem_ready) -> control word.
module multicycle_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t          i_state,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    output ctrl_t           o_ctrl
);

    // Per-state strobes; everything not named in a state stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_IDLE: begin
                o_ctrl = '0;
            end
            S_FETCH: begin
                // PC/IR only load on the cycle the memory actually returns data
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMM_SH;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.illegal_op = ~op_is_legal(i_op);
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_RTYPE;
            end
            S_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                case (i_op)
                    OP_ANDI: o_ctrl.alu_op = ALU_AND;
                    OP_ORI:  o_ctrl.alu_op = ALU_OR;
                    OP_LUI:  o_ctrl.alu_op = ALU_LUI;
                    default: o_ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = (i_op == OP_R) ? 1'b1 : 1'b0;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = (i_op == OP_SW) ? ALU_SW : ALU_LW;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                if (i_op == OP_BNE) begin
                    o_ctrl.alu_op   = ALU_BNE;
                    o_ctrl.pc_write = ~i_zero;
                end else begin
                    o_ctrl.alu_op   = ALU_BEQ;
                    o_ctrl.pc_write = i_zero;
                end
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
                if (i_op == OP_JAL) begin
                    o_ctrl.jal       = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                end else begin
                    o_ctrl.jal       = 1'b0;
                    o_ctrl.reg_write = 1'b0;
                end
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register + next-state logic around the
// output decoder. MEM_READY_EN lets FETCH/MEM_RD/MEM_WR stall on mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_mem_ready;

`ifdef MEM_READY_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    // State register; async reset drops every strobe without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:     w_next_state = S_FETCH;
            S_FETCH:    w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_R:                                w_next_state = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:    w_next_state = S_I_EXEC;
                    OP_LW, OP_SW:                        w_next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                      w_next_state = S_BRANCH;
                    OP_J, OP_JAL:                        w_next_state = S_JUMP;
                    default:                             w_next_state = S_FETCH;
                endcase
            end
            S_R_EXEC:   w_next_state = S_ALU_WB;
            S_I_EXEC:   w_next_state = S_ALU_WB;
            S_ALU_WB:   w_next_state = S_FETCH;
            S_MEM_ADDR: w_next_state = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next_state = w_mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   w_next_state = S_FETCH;
            S_MEM_WR:   w_next_state = w_mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JUMP:     w_next_state = S_FETCH;
            default:    w_next_state = S_IDLE;
        endcase
    end

    multicycle_output_decode u_output_decode (
        .i_state     (r_state),
        .i_op        (bus.op),
        .i_zero      (bus.zero),
        .i_mem_ready (w_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.pc_write   = w_ctrl.pc_write;
    assign bus.ir_write   = w_ctrl.ir_write;
    assign bus.iord       = w_ctrl.iord;
    assign bus.mem_read   = w_ctrl.mem_read;
    assign bus.mem_write  = w_ctrl.mem_write;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.jal        = w_ctrl.jal;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.pc_src     = w_ctrl.pc_src;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.illegal_op = w_ctrl.illegal_op;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its
// expected per-cycle control trace from the opcode rules and compared cycle by cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic       illegal_op;
    } cyc_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    cyc_t exp_q[$];
    bit   wait_q[$];
    logic [5:0] op_pool [13] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                                 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h11};

    always #5 clk = ~clk;

    multicycle_control_if bus_if ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cyc_t observed();
        cyc_t c;
        c.st         = bus_if.state;
        c.pc_write   = bus_if.pc_write;
        c.ir_write   = bus_if.ir_write;
        c.iord       = bus_if.iord;
        c.mem_read   = bus_if.mem_read;
        c.mem_write  = bus_if.mem_write;
        c.reg_write  = bus_if.reg_write;
        c.reg_dst    = bus_if.reg_dst;
        c.mem_to_reg = bus_if.mem_to_reg;
        c.jal        = bus_if.jal;
        c.alu_src_a  = bus_if.alu_src_a;
        c.alu_src_b  = bus_if.alu_src_b;
        c.pc_src     = bus_if.pc_src;
        c.alu_op     = bus_if.alu_op;
        c.illegal_op = bus_if.illegal_op;
        return c;
    endfunction

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c = '0;
        c.st = st;
        return c;
    endfunction

    // Expected trace of one instruction, FETCH through its last cycle.
    task automatic build_trace(input logic [5:0] op, input logic zero);
        cyc_t c;
        bit   legal;
        legal = op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                           6'h04, 6'h05, 6'h02, 6'h03};
        c = blank(4'd1); c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_b = 2'b01; c.alu_op = 4'b0100;
        exp_q.push_back(c); wait_q.push_back(1'b1);
        c = blank(4'd2); c.alu_src_b = 2'b11; c.alu_op = 4'b0100; c.illegal_op = !legal;
        exp_q.push_back(c); wait_q.push_back(1'b0);
        if (op == 6'h00) begin
            c = blank(4'd3); c.alu_src_a = 1'b1; c.alu_op = 4'b0111;
            exp_q.push_back(c); wait_q.push_back(1'b0);
            c = blank(4'd5); c.reg_write = 1'b1; c.reg_dst = 1'b1;
            exp_q.push_back(c); wait_q.push_back(1'b0);
        end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) begin
            c = blank(4'd4); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            c.alu_op = (op == 6'h08) ? 4'b0100 : (op == 6'h0C) ? 4'b0101 :
                       (op == 6'h0D) ? 4'b0110 : 4'b0011;
            exp_q.push_back(c); wait_q.push_back(1'b0);
            c = blank(4'd5); c.reg_write = 1'b1;
            exp_q.push_back(c); wait_q.push_back(1'b0);
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = blank(4'd6); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            c.alu_op = (op == 6'h23) ? 4'b1010 : 4'b1011;
            exp_q.push_back(c); wait_q.push_back(1'b0);
            if (op == 6'h23) begin
                c = blank(4'd7); c.mem_read = 1'b1; c.iord = 1'b1;
                exp_q.push_back(c); wait_q.push_back(1'b1);
                c = blank(4'd8); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                exp_q.push_back(c); wait_q.push_back(1'b0);
            end else begin
                c = blank(4'd9); c.mem_write = 1'b1; c.iord = 1'b1;
                exp_q.push_back(c); wait_q.push_back(1'b1);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = blank(4'd10); c.alu_src_a = 1'b1; c.pc_src = 2'b01;
            c.alu_op   = (op == 6'h04) ? 4'b1000 : 4'b1001;
            c.pc_write = (op == 6'h04) ? zero : !zero;
            exp_q.push_back(c); wait_q.push_back(1'b0);
        end else if (op == 6'h02 || op == 6'h03) begin
            c = blank(4'd11); c.pc_src = 2'b10; c.pc_write = 1'b1;
            c.jal = (op == 6'h03); c.reg_write = (op == 6'h03);
            exp_q.push_back(c); wait_q.push_back(1'b0);
        end else begin
            legal = 1'b0;
        end
    endtask

    // Drive one instruction from a FETCH sample point and check every cycle.
    task automatic run_instr(input logic [5:0] op, input logic zero, input int nwait, input string name);
        cyc_t  e;
        bit    w;
        string tag;
        build_trace(op, zero);
        bus_if.op   = op;
        bus_if.zero = zero;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = wait_q.pop_front();
            tag = $sformatf("%s st%0d nw%0d%s", name, e.st, nwait, w ? "*" : "");
`ifdef MEM_READY_EN
            if (w) begin
                for (int k = 0; k < nwait; k++) begin
                    cyc_t h = e;
                    h.pc_write = 1'b0;
                    h.ir_write = 1'b0;
                    bus_if.mem_ready = 1'b0;
                    #1;
                    check_eq({tag, " wait"}, observed(), h);
                    @(posedge clk); #1;
                end
            end
            bus_if.mem_ready = 1'b1;
`endif
            #1;
            check_eq(tag, observed(), e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_if.op   = 6'h00;
        bus_if.zero = 1'b0;
`ifdef MEM_READY_EN
        bus_if.mem_ready = 1'b1;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", bus_if.state, 32'd0);
        check_eq("reset_outs", observed(), blank(4'd0));
        @(negedge clk) reset = 1'b0;
        #1;
        check_eq("idle_after_reset", observed(), blank(4'd0));
        @(posedge clk); #1;

        run_instr(6'h00, 1'b0, 0, "r_type");
        run_instr(6'h23, 1'b0, 0, "lw");
        run_instr(6'h05, 1'b1, 0, "bne_z1");
        run_instr(6'h05, 1'b0, 0, "bne_z0");
        run_instr(6'h04, 1'b1, 0, "beq_z1");
        run_instr(6'h03, 1'b0, 0, "jal");
        run_instr(6'h3F, 1'b0, 0, "illegal");
        run_instr(6'h0F, 1'b0, 3, "lui_wait3");
        run_instr(6'h2B, 1'b0, 0, "sw");

        for (int i = 0; i < 40; i++) begin
            run_instr(op_pool[$urandom_range(0, 12)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        // Async reset while the store strobe is high.
        bus_if.op = 6'h2B;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_state", bus_if.state, 32'd9);
        check_eq("pre_rst_memwr", bus_if.mem_write, 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_memwr", bus_if.mem_write, 32'd0);
        check_eq("async_rst_state", bus_if.state, 32'd0);
        @(negedge clk) reset = 1'b0;
        #1;
        check_eq("idle_after_rst2", observed(), blank(4'd0));
        @(posedge clk); #1;
        run_instr(6'h0D, 1'b0, 1, "ori_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences a multicycle MIPS datapath: one shared memory, one ALU, with IR, A/B, ALUOut and MDR registers.
- Decodes the same opcode set as the single-cycle decoder: R, ADDI, ANDI, ORI, LUI, BEQ, BNE, LW, SW, J, JAL.
- Issues per-cycle mux selects, write enables and the 4-bit ALUOp to the datapath and to the ALU control.
- Sits between the instruction register (opcode field) and the datapath; it is the only source of PC/IR/RF/memory strobes.

Parameters:
- OP_W, 6, opcode width (IR[31:26])
- ALUOP_W, 4, ALUOp width presented to ALU control

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  opcode from IR; valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- pc_write  out  1  PC load enable (unconditional or branch-qualified)
- ir_write  out  1  IR load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register-file write enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- jal  out  1  forces write register 31 and write data = PC
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  4  ALU control code
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State register is the only sequential element. Reset is asynchronous: state goes to IDLE. All outputs are combinational from state, plus zero in BRANCH.
- IDLE (code 0): all outputs 0; next state is FETCH. This gives exactly one idle cycle after reset deasserts.
- FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=0100 (add), pc_src=00, pc_write=1. Next: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=0100; ALUOut receives the branch target.
- DECODE next-state by op:
  - 000000 -> R_EXEC
  - 001000 / 001100 / 001101 / 001111 -> I_EXEC
  - 100011 / 101011 -> MEM_ADDR
  - 000100 / 000101 -> BRANCH
  - 000010 / 000011 -> JUMP
  - any other op -> FETCH with illegal_op=1
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=0111. Next: ALU_WB.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op by op: ADDI 0100, ANDI 0101, ORI 0110, LUI 0011. Next: ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 when op=R, else 0. Next: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=1010 (LW) or 1011 (SW). Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. Next: MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WR: mem_write=1, iord=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=1000 (BEQ) or 1001 (BNE), pc_src=01. pc_write = zero for BEQ, !zero for BNE. Next: FETCH.
- JUMP: pc_src=10, pc_write=1. For JAL, additionally jal=1 and reg_write=1; PC still holds PC+4 in this cycle. Next: FETCH.
- Latency in cycles, FETCH through last state:
  - R / ADDI / ANDI / ORI / LUI: 4
  - LW: 5
  - SW: 4
  - BEQ / BNE: 3
  - J / JAL: 3
  - illegal opcode: 2
- Any output not listed for a state is 0.
- Unused state codes go to IDLE.
- Reset asserted mid-instruction: all strobes drop immediately (asynchronous); no partial write survives past the reset edge.
- op changing outside DECODE/EXEC has no effect on the sequence except where op selects outputs in the current state.

Optional Feature:
- Macro: MEM_READY_EN.
- Defined:
  - Adds input port mem_ready (1 bit).
  - FETCH, MEM_RD and MEM_WR hold their state and outputs while mem_ready=0.
  - In FETCH, pc_write and ir_write are asserted only in the cycle where mem_ready=1.
  - Latency grows by one cycle per wait cycle.
- Undefined: no mem_ready port; memory is always single-cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode localparams (R, ADDI, ORI, LUI, ANDI, BEQ, BNE, LW, SW, J, JAL)
  - ALUOp codes (0011, 0100–0111, 1000–1011)
  - state encoding (4-bit: IDLE=0, FETCH, DECODE, R_EXEC, I_EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP)
  - alu_src_b and pc_src encodings
- One sub-module, multicycle_output_decode: purely combinational map from (state, op, zero) to all outputs. The top module keeps the state register and next-state logic.

Test Plan:
- Reset then op=000000 held -> IDLE, FETCH(pc_write=1, ir_write=1), DECODE, R_EXEC(alu_op=0111), ALU_WB(reg_write=1, reg_dst=1), back to FETCH; 5 cycles from reset release.
- op=100011 (LW) -> MEM_ADDR alu_op=1010, MEM_RD mem_read=1 iord=1, MEM_WB reg_write=1 mem_to_reg=1; 5 cycles FETCH→FETCH.
- op=000101 (BNE) with zero=1 -> BRANCH pc_write=0; repeat with zero=0 -> pc_write=1, pc_src=01; 3 cycles.
- op=000011 (JAL) -> JUMP with pc_write=1, pc_src=10, jal=1, reg_write=1.
- op=111111 -> DECODE asserts illegal_op for 1 cycle and returns to FETCH; no reg_write or mem_write issued.
- Reset asserted during MEM_WR -> mem_write falls without waiting for a clock edge; state=IDLE. With MEM_READY_EN and mem_ready low for 3 cycles in FETCH: state holds 3 cycles, and pc_write pulses once.
